// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART transmit/receive pair.
//   tx_state_t   : transmitter FSM state encoding (3 bits)
//   PARITY_EVEN  : parity sense selector, even parity
//   PARITY_ODD   : parity sense selector, odd parity
//   calc_parity  : parity of up to MAX_DATA_BITS data bits
// State labels carry a TX_ prefix so they cannot collide with the PARITY
// parameter of the modules that import this package.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_SYNC   = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
        TX_PARITY = 3'd4,
        TX_STOP   = 3'd5
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int MAX_DATA_BITS = 9;

    // Narrower words are zero-extended by the caller; zeros do not change
    // the XOR, so one function serves every DATA_BITS setting.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// Serialises one parallel word per accepted request into a UART frame:
// start bit, DATA_BITS data bits LSB first, optional parity bit, SB_TICKS
// stop bits. Bit timing comes from the external one-cycle baud enable.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   tx_tick   in   baud enable, one pulse per bit boundary
//   tx_start  in   send request, only looked at while idle
//   tx_din    in   word to send, captured on acceptance
//   tx        out  serial line, idles high, registered
//   tx_busy   out  high whenever the FSM is not idle
//   tx_done   out  one-cycle pulse when the last stop bit period ends
// ---------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 1,
    parameter int IS_PARITY = 0,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_din,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS);
    localparam logic [1:0]        LAST_STOP = 2'(SB_TICKS - 1);
    localparam logic              ODD_SENSE = (PARITY != 0) ? PARITY_ODD : PARITY_EVEN;
    localparam logic              HAS_PAR   = (IS_PARITY != 0);

    tx_state_t              state_q,    state_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic [CNT_W-1:0]       bit_cnt_q,  bit_cnt_d;
    logic [1:0]             stop_cnt_q, stop_cnt_d;
    logic                   parity_q,   parity_d;
    logic                   tx_q,       tx_d;
    logic                   done_q,     done_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Every line change is scheduled for an edge where
    // tx_tick is high, so each bit occupies exactly one tick interval.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                // A tick coinciding with acceptance is deliberately ignored;
                // SYNC waits for the next one so the start bit is full length.
                if (tx_start) begin
                    shift_d  = tx_din;
                    parity_d = calc_parity(MAX_DATA_BITS'(tx_din), ODD_SENSE);
                    state_d  = TX_SYNC;
                end
            end
            TX_SYNC: begin
                tx_d = 1'b1;
                if (tx_tick) begin
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (bit_cnt_q < LAST_BIT) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (HAS_PAR) begin
                        tx_d    = parity_q;
                        state_d = TX_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = '0;
                        state_d    = TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = '0;
                    state_d    = TX_STOP;
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (tx_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = TX_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all straight from registers, busy decoded from state.
    // ------------------------------------------------------------------
    always_comb begin
        tx      = tx_q;
        tx_busy = (state_q != TX_IDLE);
        tx_done = done_q;
    end

endmodule
